sram_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for a single-port synchronous SRAM (posedge-sampled, active-low chip select and write enable, one-cycle read latency).
- Shares one SRAM instance between two independent masters, A and B, using round-robin ownership with a bounded burst length.
- Drives the SRAM control, address and write-data pins directly, and returns read data to the originating master with a valid strobe.
- Sits between the SRAM and its clients in the same sub-block.

---
 rtl/sram_port_arbiter_if.sv | 46 ++++
 rtl/sram_port_arbiter.sv | 155 +++++++++++++++
 tb/tb_sram_port_arbiter.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Bus bundle between the SRAM arbiter, its two masters (A and B) and the SRAM macro pins.
interface sram_port_arbiter_if #(
  parameter int DW = 32,
  parameter int AW = 10
);
  logic          req_a;
  logic          we_a;
  logic [AW-1:0] addr_a;
  logic [DW-1:0] wdata_a;
  logic          gnt_a;
  logic          rvalid_a;
  logic [DW-1:0] rdata_a;

  logic          req_b;
  logic          we_b;
  logic [AW-1:0] addr_b;
  logic [DW-1:0] wdata_b;
  logic          gnt_b;
  logic          rvalid_b;
  logic [DW-1:0] rdata_b;

  logic          ram_n_cs;
  logic          ram_n_we;
  logic          ram_n_oe;
  logic [AW-1:0] ram_ad;
  logic [DW-1:0] ram_din;
  logic [DW-1:0] ram_dout;

  modport slave (
    input  req_a, we_a, addr_a, wdata_a,
    input  req_b, we_b, addr_b, wdata_b,
    output gnt_a, rvalid_a, rdata_a,
    output gnt_b, rvalid_b, rdata_b,
    output ram_n_cs, ram_n_we, ram_n_oe, ram_ad, ram_din,
    input  ram_dout
  );

  modport master (
    output req_a, we_a, addr_a, wdata_a,
    output req_b, we_b, addr_b, wdata_b,
    input  gnt_a, rvalid_a, rdata_a,
    input  gnt_b, rvalid_b, rdata_b,
    input  ram_n_cs, ram_n_we, ram_n_oe, ram_ad, ram_din,
    output ram_dout
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Round-robin, burst-limited arbiter sharing one single-port SRAM between masters A and B.
// Optional macro SRAM_ARB_RDHOLD_EN: rdata_x holds the last read value between reads.
//
// state | meaning
// IDLE  | no owner; ties go to the master not granted last
// OWN_A | A granted last cycle; keeps the port up to BURST_MAX grants while B waits
// OWN_B | B granted last cycle; keeps the port up to BURST_MAX grants while A waits
module sram_port_arbiter #(
  parameter int DW        = 32,
  parameter int AW        = 10,
  parameter int BURST_MAX = 4
) (
  input  logic                 clk,
  input  logic                 n_reset,
  sram_port_arbiter_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_t;

  localparam logic [3:0] BMAX = 4'(BURST_MAX);

  state_t     state_q, state_d;
  logic [3:0] bcnt_q, bcnt_d;
  logic       last_q, last_d;
  logic       tag_vld_q, tag_vld_d;
  logic       tag_id_q, tag_id_d;
  logic       gnt_a, gnt_b;
  logic       rvalid_a, rvalid_b;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      bcnt_q    <= 4'd0;
      last_q    <= 1'b1;
      tag_vld_q <= 1'b0;
      tag_id_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      bcnt_q    <= bcnt_d;
      last_q    <= last_d;
      tag_vld_q <= tag_vld_d;
      tag_id_q  <= tag_id_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    last_d  = last_q;
    gnt_a   = 1'b0;
    gnt_b   = 1'b0;

    // Grants are combinational, so they are gated while reset is held
    if (n_reset) begin
      case (state_q)
        IDLE: begin
          if (bus.req_a && (!bus.req_b || last_q)) gnt_a = 1'b1;
          else if (bus.req_b)                      gnt_b = 1'b1;
        end
        OWN_A: begin
          if (bus.req_a && (!bus.req_b || bcnt_q < BMAX)) gnt_a = 1'b1;
          else if (bus.req_b)                             gnt_b = 1'b1;
        end
        OWN_B: begin
          if (bus.req_b && (!bus.req_a || bcnt_q < BMAX)) gnt_b = 1'b1;
          else if (bus.req_a)                             gnt_a = 1'b1;
        end
        default: ;
      endcase
    end

    if (gnt_a) begin
      last_d = 1'b0;
      if (state_q == OWN_A) begin
        bcnt_d = (bcnt_q < BMAX) ? 4'(bcnt_q + 4'd1) : bcnt_q;
      end else begin
        state_d = OWN_A;
        bcnt_d  = 4'd1;
      end
    end else if (gnt_b) begin
      last_d = 1'b1;
      if (state_q == OWN_B) begin
        bcnt_d = (bcnt_q < BMAX) ? 4'(bcnt_q + 4'd1) : bcnt_q;
      end else begin
        state_d = OWN_B;
        bcnt_d  = 4'd1;
      end
    end else begin
      state_d = IDLE;
      bcnt_d  = 4'd0;
    end
  end

  always_comb begin
    bus.ram_n_cs = 1'b1;
    bus.ram_n_we = 1'b1;
    bus.ram_ad   = {AW{1'b0}};
    bus.ram_din  = {DW{1'b0}};
    tag_vld_d    = 1'b0;
    tag_id_d     = 1'b0;
    if (gnt_a) begin
      bus.ram_n_cs = 1'b0;
      bus.ram_n_we = ~bus.we_a;
      bus.ram_ad   = bus.addr_a;
      bus.ram_din  = bus.wdata_a;
      tag_vld_d    = ~bus.we_a;
    end else if (gnt_b) begin
      bus.ram_n_cs = 1'b0;
      bus.ram_n_we = ~bus.we_b;
      bus.ram_ad   = bus.addr_b;
      bus.ram_din  = bus.wdata_b;
      tag_vld_d    = ~bus.we_b;
      tag_id_d     = 1'b1;
    end
  end

  assign bus.gnt_a    = gnt_a;
  assign bus.gnt_b    = gnt_b;
  assign bus.ram_n_oe = 1'b0;
  assign rvalid_a     = tag_vld_q & ~tag_id_q;
  assign rvalid_b     = tag_vld_q &  tag_id_q;
  assign bus.rvalid_a = rvalid_a;
  assign bus.rvalid_b = rvalid_b;

`ifdef SRAM_ARB_RDHOLD_EN
  logic [DW-1:0] hold_a_q, hold_a_d;
  logic [DW-1:0] hold_b_q, hold_b_d;

  always_comb begin
    hold_a_d = rvalid_a ? bus.ram_dout : hold_a_q;
    hold_b_d = rvalid_b ? bus.ram_dout : hold_b_q;
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      hold_a_q <= {DW{1'b0}};
      hold_b_q <= {DW{1'b0}};
    end else begin
      hold_a_q <= hold_a_d;
      hold_b_q <= hold_b_d;
    end
  end

  assign bus.rdata_a = rvalid_a ? bus.ram_dout : hold_a_q;
  assign bus.rdata_b = rvalid_b ? bus.ram_dout : hold_b_q;
`else
  assign bus.rdata_a = rvalid_a ? bus.ram_dout : {DW{1'b0}};
  assign bus.rdata_b = rvalid_b ? bus.ram_dout : {DW{1'b0}};
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: behavioural SRAM, grant-sequence checks and a read-data scoreboard.
module tb_sram_port_arbiter;
  localparam int DW   = 32;
  localparam int AW   = 10;
  localparam int BMAX = 4;
`ifdef SRAM_ARB_RDHOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct packed {
    int            due;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic n_reset = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sram_port_arbiter_if #(.DW(DW), .AW(AW)) bus ();

  sram_port_arbiter #(.DW(DW), .AW(AW), .BURST_MAX(BMAX)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus)
  );

  // behavioural single-port SRAM, one-cycle read latency
  logic [DW-1:0] sram_mem [0:(1<<AW)-1];
  logic [DW-1:0] sram_q = '0;
  always @(posedge clk) begin
    if (!bus.ram_n_cs) begin
      if (!bus.ram_n_we) sram_mem[bus.ram_ad] <= bus.ram_din;
      else               sram_q <= sram_mem[bus.ram_ad];
    end
  end
  assign bus.ram_dout = sram_q;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scoreboard: expected read data keyed by the cycle it must appear in
  logic [DW-1:0] ref_mem [0:(1<<AW)-1];
  exp_t          q_a[$];
  exp_t          q_b[$];
  exp_t          e;
  logic [DW-1:0] hold_a = '0;
  logic [DW-1:0] hold_b = '0;

  always @(negedge clk) begin
    if (!n_reset) begin
      q_a.delete();
      q_b.delete();
      hold_a = '0;
      hold_b = '0;
      chk("rst_gnt",    {bus.gnt_a, bus.gnt_b}, 0);
      chk("rst_cs",     bus.ram_n_cs, 1);
      chk("rst_rvalid", {bus.rvalid_a, bus.rvalid_b}, 0);
      chk("rst_rdata_a", bus.rdata_a, 0);
      chk("rst_rdata_b", bus.rdata_b, 0);
    end else begin
      if (q_a.size() != 0 && q_a[0].due == cyc) begin
        chk("rvalid_a", bus.rvalid_a, 1);
        chk("rdata_a",  bus.rdata_a, q_a[0].data);
        if (HOLD) hold_a = q_a[0].data;
        void'(q_a.pop_front());
      end else begin
        chk("rvalid_a_idle", bus.rvalid_a, 0);
        chk("rdata_a_idle",  bus.rdata_a, hold_a);
      end
      if (q_b.size() != 0 && q_b[0].due == cyc) begin
        chk("rvalid_b", bus.rvalid_b, 1);
        chk("rdata_b",  bus.rdata_b, q_b[0].data);
        if (HOLD) hold_b = q_b[0].data;
        void'(q_b.pop_front());
      end else begin
        chk("rvalid_b_idle", bus.rvalid_b, 0);
        chk("rdata_b_idle",  bus.rdata_b, hold_b);
      end

      chk("gnt_excl", bus.gnt_a & bus.gnt_b, 0);
      chk("ram_cs",   bus.ram_n_cs, !(bus.gnt_a || bus.gnt_b));
      chk("ram_oe",   bus.ram_n_oe, 0);
      if (bus.gnt_a) begin
        chk("ram_ad_a",  bus.ram_ad, bus.addr_a);
        chk("ram_we_a",  bus.ram_n_we, !bus.we_a);
        chk("ram_din_a", bus.ram_din, bus.wdata_a);
        if (bus.we_a) ref_mem[bus.addr_a] = bus.wdata_a;
        else begin
          e.due  = cyc + 1;
          e.data = ref_mem[bus.addr_a];
          q_a.push_back(e);
        end
      end else if (bus.gnt_b) begin
        chk("ram_ad_b",  bus.ram_ad, bus.addr_b);
        chk("ram_we_b",  bus.ram_n_we, !bus.we_b);
        chk("ram_din_b", bus.ram_din, bus.wdata_b);
        if (bus.we_b) ref_mem[bus.addr_b] = bus.wdata_b;
        else begin
          e.due  = cyc + 1;
          e.data = ref_mem[bus.addr_b];
          q_b.push_back(e);
        end
      end else begin
        chk("ram_ad_idle",  bus.ram_ad, 0);
        chk("ram_din_idle", bus.ram_din, 0);
        chk("ram_we_idle",  bus.ram_n_we, 1);
      end
    end
  end

  // one cycle of stimulus: drive just after the edge, return at the following falling edge
  task automatic drv(input logic ra, input logic wa, input logic [AW-1:0] aa, input logic [DW-1:0] da,
                     input logic rb, input logic wb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    @(posedge clk);
    #1;
    bus.req_a = ra; bus.we_a = wa; bus.addr_a = aa; bus.wdata_a = da;
    bus.req_b = rb; bus.we_b = wb; bus.addr_b = ab; bus.wdata_b = db;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drv(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  task automatic gexp(input string tag, input logic ea, input logic eb);
    chk({tag, "_gnt_a"}, bus.gnt_a, ea);
    chk({tag, "_gnt_b"}, bus.gnt_b, eb);
  endtask

  // requests held high through reset must not be granted
  task automatic do_reset();
    @(posedge clk);
    #1;
    n_reset   = 1'b0;
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = 10'd5;
    bus.req_b = 1'b1; bus.we_b = 1'b1; bus.addr_b = 10'd9;
    repeat (2) @(posedge clk);
    #1;
    bus.req_a = 1'b0; bus.req_b = 1'b0; bus.we_a = 1'b0; bus.we_b = 1'b0;
    n_reset   = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.req_a = 1'b1; bus.we_a = 1'b0; bus.addr_a = '0; bus.wdata_a = '0;
    bus.req_b = 1'b0; bus.we_b = 1'b0; bus.addr_b = '0; bus.wdata_b = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.req_a = 1'b0;
    n_reset   = 1'b1;

    // single write then read by A, plus seeding addresses 1 and 2
    drv(1, 1, 10'd5, 32'hDEADBEEF, 0, 0, '0, '0);
    gexp("t1_wr", 1, 0);
    chk("t1_wr_we", bus.ram_n_we, 0);
    drv(1, 0, 10'd5, '0, 0, 0, '0, '0);
    gexp("t1_rd", 1, 0);
    chk("t1_rd_we", bus.ram_n_we, 1);
    drv(1, 1, 10'd1, 32'h11, 0, 0, '0, '0);
    gexp("t1_seed1", 1, 0);
    drv(0, 0, '0, '0, 1, 1, 10'd2, 32'h22);
    gexp("t1_seed2", 0, 1);
    idle(2);

    // tie after reset: A first, then BURST_MAX grants each, alternating with no bubble
    do_reset();
    for (int i = 0; i < 4 * BMAX; i++) begin
      drv(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
      gexp($sformatf("t2_%0d", i), ((i / BMAX) % 2) == 0, ((i / BMAX) % 2) == 1);
    end
    idle(2);

    // burst release: A drops after 2 grants, B takes over with a fresh count
    do_reset();
    drv(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
    gexp("t3_0", 1, 0);
    drv(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
    gexp("t3_1", 1, 0);
    drv(0, 0, '0, '0, 1, 0, 10'd2, '0);
    gexp("t3_2", 0, 1);
    for (int i = 3; i < 6; i++) begin
      drv(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
      gexp($sformatf("t3_%0d", i), 0, 1);
    end
    drv(1, 0, 10'd1, '0, 1, 0, 10'd2, '0);
    gexp("t3_6", 1, 0);
    idle(2);

    // interleaved reads: rvalid_a then rvalid_b on consecutive cycles
    drv(1, 0, 10'd1, '0, 0, 0, '0, '0);
    gexp("t4_a", 1, 0);
    drv(0, 0, '0, '0, 1, 0, 10'd2, '0);
    gexp("t4_b", 0, 1);
    chk("t4_rvalid_a", bus.rvalid_a, 1);
    chk("t4_rdata_a",  bus.rdata_a, 32'h11);
    idle(1);
    chk("t4_rvalid_b", bus.rvalid_b, 1);
    chk("t4_rdata_b",  bus.rdata_b, 32'h22);
    idle(1);

    // reset asserted while a read is outstanding
    drv(1, 0, 10'd5, '0, 0, 0, '0, '0);
    gexp("t5_rd", 1, 0);
    @(posedge clk);
    #1;
    n_reset   = 1'b0;
    bus.req_a = 1'b0;
    @(negedge clk);
    chk("t5_rvalid_a", bus.rvalid_a, 0);
    chk("t5_cs",       bus.ram_n_cs, 1);
    @(posedge clk);
    #1;
    n_reset = 1'b1;
    idle(4);

    // read-data hold across unrelated B traffic
    drv(1, 0, 10'd1, '0, 0, 0, '0, '0);
    gexp("t6_a", 1, 0);
    drv(0, 0, '0, '0, 1, 1, 10'd3, 32'h33);
    gexp("t6_b0", 0, 1);
    chk("t6_rdata_a_valid", bus.rdata_a, 32'h11);
    drv(0, 0, '0, '0, 1, 0, 10'd2, '0);
    gexp("t6_b1", 0, 1);
    chk("t6_hold_1", bus.rdata_a, HOLD ? 32'h11 : 32'h0);
    drv(0, 0, '0, '0, 1, 1, 10'd4, 32'h44);
    gexp("t6_b2", 0, 1);
    chk("t6_hold_2", bus.rdata_a, HOLD ? 32'h11 : 32'h0);
    idle(3);
    chk("t6_hold_3", bus.rdata_a, HOLD ? 32'h11 : 32'h0);

    chk("sb_drained", q_a.size() + q_b.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
